nmr_qsw_seq_ctrl: RTL and testbench
===================================

# nmr_qsw_seq_ctrl

Multi-echo Q-switch/acquisition sequencer for the NMR receive path. On a START pulse it runs ECHO_NUM echo periods. Each period drives the Q-switch enable, then a dead time, then the ADC acquisition window, then an idle gap. Its QSW_EN and ACQ_WND outputs feed the Q-switch driver and the ADC capture logic, all in the ADC_CLK domain.

## Interface
- CNT_W, 16, width of all phase-length inputs (cycles)
- ECHO_W, 12, width of ECHO_NUM and ECHO_IDX
- ADC_CLK  in  1  system clock; all logic on posedge
- RESET  in  1  asynchronous, active-high
- START  in  1  one-cycle start pulse, synchronous to ADC_CLK
- ABORT  in  1  synchronous abort (present only with NMR_QSW_SEQ_ABORT_EN)
- ECHO_NUM  in  ECHO_W  number of echoes; latched at START
- T_QSW_ON  in  CNT_W  Q-switch enable length; latched at START
- T_QSW_DLY  in  CNT_W  dead time between QSW off and ACQ on; latched at START
- T_ACQ  in  CNT_W  acquisition window length; latched at START
- T_ECHO  in  CNT_W  echo period; latched at START
- QSW_EN  out  1  Q-switch enable, registered
- ACQ_WND  out  1  acquisition window, registered
- BUSY  out  1  high from accepted START until sequence end
- DONE  out  1  one-cycle pulse at normal completion
- ECHO_IDX  out  ECHO_W  current echo index, 0..ECHO_NUM-1

## Operation
- States: IDLE, QSW, DEAD, ACQ, GAP.
- IDLE: START=1 latches all T_* and ECHO_NUM, clears ECHO_IDX, and sets BUSY.
  - ECHO_NUM=0: DONE pulses, BUSY stays low.
  - Otherwise: enter first non-zero phase of echo 0.
- Each phase of length L lasts exactly L cycles. L=0 skips the phase, with no output glitch.
- QSW asserts QSW_EN. ACQ asserts ACQ_WND. DEAD and GAP assert neither. QSW_EN and ACQ_WND are never high together.
- Echo period P = max(T_ECHO, T_QSW_ON+T_QSW_DLY+T_ACQ, 1). GAP length = P - (T_QSW_ON+T_QSW_DLY+T_ACQ). The sum is computed in CNT_W+2 bits, with no wrap.
- End of echo:
  - If ECHO_IDX = ECHO_NUM-1: go to IDLE, pulse DONE, drop BUSY.
  - Else: increment ECHO_IDX and start the next echo's first non-zero phase.
- If all three phase lengths are 0, the echo is one GAP cycle.
- START while BUSY: ignored. Inputs are not re-latched mid-sequence.
- ECHO_IDX holds its last value in IDLE until the next START.

## Timing
- Reset values: QSW_EN=0, ACQ_WND=0, BUSY=0, DONE=0, ECHO_IDX=0, state IDLE, latched params 0.
- Latency: the first output transition is registered on the same edge that samples START=1.
  - Example: START sampled at edge k with T_QSW_ON>0 gives QSW_EN=1 during cycles k..k+T_QSW_ON-1.
- Echo n begins exactly n·P cycles after edge k.
- DONE and BUSY fall on the edge after the last cycle of the final echo.
  - A START in that same DONE cycle is accepted.
- RESET mid-sequence: all outputs low immediately (asynchronous), FSM to IDLE, no DONE.

## Configuration
- NMR_QSW_SEQ_ABORT_EN defined:
  - ABORT port exists.
  - ABORT=1 forces IDLE on the next edge, with QSW_EN, ACQ_WND and BUSY low and no DONE.
  - ABORT has priority over a simultaneous START.
  - ABORT in IDLE has no effect.
- Undefined: no ABORT port; a sequence always runs to completion or RESET.

## Structure
- Shared package nmr_qsw_seq_pkg holds:
  - state enum (one-hot encoding constants);
  - default CNT_W/ECHO_W;
  - the phase-length sum width constant.
- Sub-module nmr_phase_timer: loadable CNT_W down-counter with load, enable and last-cycle flag, instantiated once. The FSM reloads it at each phase entry.

## Test plan
- ECHO_NUM=2, T_QSW_ON=4, T_QSW_DLY=3, T_ACQ=10, T_ECHO=25, START at edge 10 -> required response:
  - QSW_EN high cycles 10–13 and 35–38;
  - ACQ_WND high cycles 17–26 and 42–51;
  - DONE pulse at cycle 60; BUSY high 10–59.
- T_ECHO=5 with T_QSW_ON=2, T_QSW_DLY=0, T_ACQ=6, ECHO_NUM=3 -> P=8; ACQ_WND directly follows QSW_EN with no gap; DONE after 24 cycles.
- ECHO_NUM=0 START -> DONE one cycle, BUSY never high; T_QSW_ON=0 -> QSW_EN never asserts, ACQ_WND timing shifts earlier accordingly.
- Second START during BUSY and changed T_* inputs mid-run -> no effect on timing of the current sequence.
- RESET asserted mid-ACQ -> ACQ_WND low asynchronously, no DONE; a new START after release runs normally.
- With NMR_QSW_SEQ_ABORT_EN: ABORT in GAP of echo 1 of 4 -> IDLE next edge, no DONE; ABORT+START in the same IDLE cycle -> sequence not started.

Source files
------------

// File: rtl/nmr_qsw_seq_pkg.sv
// nmr_qsw_seq_pkg
// Shared definitions for the multi-echo Q-switch/acquisition sequencer:
//   - default counter and echo-index widths
//   - headroom bits for the three-term phase-length sum
//   - one-hot FSM state constants and the phase index enum
//   - helpers mapping between phases and FSM states, and a
//     "first non-zero phase at or after position N" search
// Optional feature macro used by the top level: NMR_QSW_SEQ_ABORT_EN.
package nmr_qsw_seq_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int ECHO_W_DEF  = 12;
   // Sum of three CNT_W lengths needs two extra bits to never wrap.
   localparam int SUM_EXTRA_W = 2;

   localparam int ST_W = 5;
   localparam logic [ST_W-1:0] ST_IDLE = 5'b00001;
   localparam logic [ST_W-1:0] ST_QSW  = 5'b00010;
   localparam logic [ST_W-1:0] ST_DEAD = 5'b00100;
   localparam logic [ST_W-1:0] ST_ACQ  = 5'b01000;
   localparam logic [ST_W-1:0] ST_GAP  = 5'b10000;

   // Phase order inside one echo period.
   typedef enum logic [1:0] {
      PH_QSW  = 2'd0,
      PH_DEAD = 2'd1,
      PH_ACQ  = 2'd2,
      PH_GAP  = 2'd3
   } phase_e;

   typedef struct packed {
      logic   ok;
      phase_e ph;
   } phase_sel_t;

   function automatic logic [ST_W-1:0] phase_state(input phase_e ph);
      case (ph)
         PH_QSW:  phase_state = ST_QSW;
         PH_DEAD: phase_state = ST_DEAD;
         PH_ACQ:  phase_state = ST_ACQ;
         default: phase_state = ST_GAP;
      endcase
   endfunction

   function automatic phase_e state_phase(input logic [ST_W-1:0] st);
      case (st)
         ST_DEAD: state_phase = PH_DEAD;
         ST_ACQ:  state_phase = PH_ACQ;
         ST_GAP:  state_phase = PH_GAP;
         default: state_phase = PH_QSW;
      endcase
   endfunction

   // Lowest phase index >= from whose length is non-zero (nz bit set).
   // Iterating downwards lets the lowest match win.
   function automatic phase_sel_t find_phase(input logic [3:0] nz, input int from);
      find_phase = '{ok: 1'b0, ph: PH_QSW};
      for (int i = 3; i >= 0; i--) begin
         if (i >= from && nz[i]) begin
            find_phase.ok = 1'b1;
            find_phase.ph = phase_e'(i[1:0]);
         end
      end
   endfunction

endpackage

// File: rtl/nmr_qsw_seq_ctrl_timer.sv
// nmr_phase_timer
// Loadable down-counter timing one sequencer phase. Loading L-1 makes
// 'last' rise on the L-th cycle of the phase.
// Ports:
//   adc_clk   in   clock, posedge
//   reset     in   asynchronous, active-high
//   load      in   load load_val this edge (has priority over en)
//   en        in   decrement while non-zero
//   load_val  in   CNT_W value to load
//   last      out  counter is zero (final cycle of the current phase)
module nmr_phase_timer
   import nmr_qsw_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             adc_clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             last
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/nmr_qsw_seq_ctrl.sv
// nmr_qsw_seq_ctrl
// Multi-echo Q-switch/acquisition sequencer. A START pulse latches the
// phase lengths and echo count, then runs ECHO_NUM echo periods of
// QSW -> DEAD -> ACQ -> GAP. Zero-length phases are skipped. The echo
// period is max(T_ECHO, T_QSW_ON+T_QSW_DLY+T_ACQ, 1); GAP fills the rest.
// Optional feature macro: NMR_QSW_SEQ_ABORT_EN adds a synchronous ABORT.
// Ports:
//   ADC_CLK    in   clock, posedge
//   RESET      in   asynchronous, active-high
//   START      in   one-cycle start request (ignored while busy)
//   ABORT      in   synchronous abort (only with NMR_QSW_SEQ_ABORT_EN)
//   ECHO_NUM   in   echo count, latched at START
//   T_QSW_ON   in   Q-switch enable length, latched at START
//   T_QSW_DLY  in   dead time, latched at START
//   T_ACQ      in   acquisition window length, latched at START
//   T_ECHO     in   echo period, latched at START
//   QSW_EN     out  Q-switch enable (registered)
//   ACQ_WND    out  acquisition window (registered)
//   BUSY       out  sequence in progress
//   DONE       out  one-cycle pulse at normal completion
//   ECHO_IDX   out  current echo index
//   SEQ_STATE  out  one-hot FSM state, for observation
// Handshake: START is a single-cycle request sampled on ADC_CLK; it is
// accepted only when the FSM is IDLE (the DONE cycle is IDLE) and, when
// present, ABORT is low. There is no ready signal; BUSY tells the
// requester a START would be dropped.
module nmr_qsw_seq_ctrl
   import nmr_qsw_seq_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int ECHO_W = ECHO_W_DEF
) (
   input  logic              ADC_CLK,
   input  logic              RESET,
   input  logic              START,
`ifdef NMR_QSW_SEQ_ABORT_EN
   input  logic              ABORT,
`endif
   input  logic [ECHO_W-1:0] ECHO_NUM,
   input  logic [CNT_W-1:0]  T_QSW_ON,
   input  logic [CNT_W-1:0]  T_QSW_DLY,
   input  logic [CNT_W-1:0]  T_ACQ,
   input  logic [CNT_W-1:0]  T_ECHO,
   output logic              QSW_EN,
   output logic              ACQ_WND,
   output logic              BUSY,
   output logic              DONE,
   output logic [ECHO_W-1:0] ECHO_IDX,
   output logic [ST_W-1:0]   SEQ_STATE
);

   localparam int SUM_W = CNT_W + SUM_EXTRA_W;

   logic [ST_W-1:0]   state, state_nxt;
   logic [ECHO_W-1:0] num_q, idx_q, idx_nxt;
   logic [CNT_W-1:0]  t_qsw_q, t_dly_q, t_acq_q, t_echo_q;
   logic              busy_q, busy_nxt, done_q, done_nxt;
   logic              qsw_q, acq_q;
   logic              latch_en, tmr_load, tmr_last, abort_req, idle;

   logic [CNT_W-1:0]  src_qsw, src_dly, src_acq, src_echo, gap_len;
   logic [SUM_W-1:0]  sum, echo_ext;
   logic [CNT_W-1:0]  ph_len [0:3];
   logic [3:0]        nz;
   phase_sel_t        first_sel, nxt_sel;
   phase_e            load_ph;

`ifdef NMR_QSW_SEQ_ABORT_EN
   assign abort_req = ABORT;
`else
   assign abort_req = 1'b0;
`endif

   assign idle = (state == ST_IDLE);

   // In IDLE the first phase of echo 0 is chosen from the live inputs,
   // because they are being latched on that same edge.
   always_comb begin
      src_qsw  = idle ? T_QSW_ON  : t_qsw_q;
      src_dly  = idle ? T_QSW_DLY : t_dly_q;
      src_acq  = idle ? T_ACQ     : t_acq_q;
      src_echo = idle ? T_ECHO    : t_echo_q;
      sum      = SUM_W'(src_qsw) + SUM_W'(src_dly) + SUM_W'(src_acq);
      echo_ext = SUM_W'(src_echo);
      // GAP only exists when T_ECHO exceeds the active phases, so it
      // always fits CNT_W. An all-zero echo still takes one GAP cycle.
      if (echo_ext > sum) begin
         gap_len = CNT_W'(echo_ext - sum);
      end else if (sum == '0) begin
         gap_len = CNT_W'(1);
      end else begin
         gap_len = '0;
      end
      ph_len[0] = src_qsw;
      ph_len[1] = src_dly;
      ph_len[2] = src_acq;
      ph_len[3] = gap_len;
      for (int i = 0; i < 4; i++) begin
         nz[i] = (ph_len[i] != '0);
      end
      first_sel = find_phase(nz, 0);
      nxt_sel   = find_phase(nz, int'(state_phase(state)) + 1);
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx_q;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      latch_en  = 1'b0;
      tmr_load  = 1'b0;
      load_ph   = first_sel.ph;
      if (!idle && abort_req) begin
         state_nxt = ST_IDLE;
         busy_nxt  = 1'b0;
      end else if (idle) begin
         if (START && !abort_req) begin
            latch_en = 1'b1;
            idx_nxt  = '0;
            if (ECHO_NUM == '0 || !first_sel.ok) begin
               done_nxt = 1'b1;
            end else begin
               state_nxt = phase_state(first_sel.ph);
               busy_nxt  = 1'b1;
               tmr_load  = 1'b1;
            end
         end
      end else if (tmr_last) begin
         if (nxt_sel.ok) begin
            state_nxt = phase_state(nxt_sel.ph);
            tmr_load  = 1'b1;
            load_ph   = nxt_sel.ph;
         end else if (idx_q == num_q - ECHO_W'(1)) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
         end else begin
            // Next echo; reload even if the state is unchanged (e.g. QSW only).
            idx_nxt   = idx_q + ECHO_W'(1);
            state_nxt = phase_state(first_sel.ph);
            tmr_load  = 1'b1;
         end
      end
   end

   nmr_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .adc_clk  (ADC_CLK),
      .reset    (RESET),
      .load     (tmr_load),
      .en       (!idle),
      .load_val (ph_len[load_ph] - CNT_W'(1)),
      .last     (tmr_last)
   );

   always_ff @(posedge ADC_CLK or posedge RESET) begin
      if (RESET) begin
         state    <= ST_IDLE;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         qsw_q    <= 1'b0;
         acq_q    <= 1'b0;
         num_q    <= '0;
         t_qsw_q  <= '0;
         t_dly_q  <= '0;
         t_acq_q  <= '0;
         t_echo_q <= '0;
      end else begin
         state  <= state_nxt;
         idx_q  <= idx_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         // Outputs decoded from the next state so they change on the
         // same edge as the state, with no combinational glitch.
         qsw_q  <= (state_nxt == ST_QSW);
         acq_q  <= (state_nxt == ST_ACQ);
         if (latch_en) begin
            num_q    <= ECHO_NUM;
            t_qsw_q  <= T_QSW_ON;
            t_dly_q  <= T_QSW_DLY;
            t_acq_q  <= T_ACQ;
            t_echo_q <= T_ECHO;
         end
      end
   end

   assign QSW_EN    = qsw_q;
   assign ACQ_WND   = acq_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ECHO_IDX  = idx_q;
   assign SEQ_STATE = state;

endmodule

// File: tb/tb_nmr_qsw_seq_ctrl.sv
// tb_nmr_qsw_seq_ctrl
// Directed bench for nmr_qsw_seq_ctrl. Cycle c of a sequence is the
// cycle after the edge that sampled START (c=0). Expected waveforms come
// from hand-written ranges or from period/offset arithmetic.
// Optional feature macro: NMR_QSW_SEQ_ABORT_EN enables the abort tests.
module tb_nmr_qsw_seq_ctrl;
   import nmr_qsw_seq_pkg::*;

   localparam int CNT_W  = 16;
   localparam int ECHO_W = 12;

   logic              ADC_CLK = 1'b0;
   logic              RESET;
   logic              START;
`ifdef NMR_QSW_SEQ_ABORT_EN
   logic              ABORT;
`endif
   logic [ECHO_W-1:0] ECHO_NUM;
   logic [CNT_W-1:0]  T_QSW_ON, T_QSW_DLY, T_ACQ, T_ECHO;
   logic              QSW_EN, ACQ_WND, BUSY, DONE;
   logic [ECHO_W-1:0] ECHO_IDX;
   logic [ST_W-1:0]   SEQ_STATE;

   int checks = 0;
   int errors = 0;

   nmr_qsw_seq_ctrl #(.CNT_W(CNT_W), .ECHO_W(ECHO_W)) dut (
      .ADC_CLK   (ADC_CLK),
      .RESET     (RESET),
      .START     (START),
`ifdef NMR_QSW_SEQ_ABORT_EN
      .ABORT     (ABORT),
`endif
      .ECHO_NUM  (ECHO_NUM),
      .T_QSW_ON  (T_QSW_ON),
      .T_QSW_DLY (T_QSW_DLY),
      .T_ACQ     (T_ACQ),
      .T_ECHO    (T_ECHO),
      .QSW_EN    (QSW_EN),
      .ACQ_WND   (ACQ_WND),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ECHO_IDX  (ECHO_IDX),
      .SEQ_STATE (SEQ_STATE)
   );

   always #5 ADC_CLK = ~ADC_CLK;

   task automatic tick();
      @(posedge ADC_CLK);
      #1;
   endtask

   task automatic start_seq(input int num, input int qon, input int dly, input int acq, input int ech);
      ECHO_NUM  = ECHO_W'(num);
      T_QSW_ON  = CNT_W'(qon);
      T_QSW_DLY = CNT_W'(dly);
      T_ACQ     = CNT_W'(acq);
      T_ECHO    = CNT_W'(ech);
      START     = 1'b1;
      tick();
      START     = 1'b0;
   endtask

   // Checks cycles 0 .. num*P+1 of a running sequence. With disturb set,
   // a second START and new random T_* values are applied mid-run.
   task automatic check_seq(input string name, input int num, input int qon, input int dly,
                            input int acq, input int ech, input bit disturb);
      int s = qon + dly + acq;
      int p = ech;
      int last;
      if (s > p) p = s;
      if (p < 1) p = 1;
      last = num * p + 1;
      for (int c = 0; c <= last; c++) begin
         bit eb = (c < num * p);
         bit ed = (c == num * p);
         bit eq = 1'b0;
         bit ea = 1'b0;
         int ei = (num > 0) ? num - 1 : 0;
         if (eb) begin
            eq = ((c % p) < qon);
            ea = ((c % p) >= qon + dly) && ((c % p) < s);
            ei = c / p;
         end
         checks++;
         if ({QSW_EN, ACQ_WND, BUSY, DONE} !== {eq, ea, eb, ed}) begin
            errors++;
            $display("FAIL %s cycle %0d qsw/acq/busy/done got %b%b%b%b want %b%b%b%b",
                     name, c, QSW_EN, ACQ_WND, BUSY, DONE, eq, ea, eb, ed);
         end
         checks++;
         if (ECHO_IDX !== ECHO_W'(ei)) begin
            errors++;
            $display("FAIL %s cycle %0d echo_idx got %0d want %0d", name, c, ECHO_IDX, ei);
         end
         if (disturb && c == 3) begin
            START     = 1'b1;
            ECHO_NUM  = ECHO_W'($urandom_range(1, 9));
            T_QSW_ON  = CNT_W'($urandom_range(1, 20));
            T_QSW_DLY = CNT_W'($urandom_range(0, 20));
            T_ACQ     = CNT_W'($urandom_range(1, 20));
            T_ECHO    = CNT_W'($urandom_range(0, 40));
         end
         if (c == 4) START = 1'b0;
         if (c < last) tick();
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      START = 1'b0;
`ifdef NMR_QSW_SEQ_ABORT_EN
      ABORT = 1'b0;
`endif
      ECHO_NUM = '0; T_QSW_ON = '0; T_QSW_DLY = '0; T_ACQ = '0; T_ECHO = '0;
      tick(); tick();
      checks++;
      if ({QSW_EN, ACQ_WND, BUSY, DONE} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outs got %b%b%b%b want 0000", QSW_EN, ACQ_WND, BUSY, DONE);
      end
      checks++;
      if (ECHO_IDX !== '0) begin
         errors++;
         $display("FAIL reset_idx got %0d want 0", ECHO_IDX);
      end
      RESET = 1'b0;
      tick();
      checks++;
      if (SEQ_STATE !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state got %b want %b", SEQ_STATE, ST_IDLE);
      end
   endtask

   // Hand-written ranges: START at edge 10 maps to c = cycle - 10.
   task automatic test_spec_example();
      start_seq(2, 4, 3, 10, 25);
      for (int c = 0; c <= 51; c++) begin
         bit eq = (c <= 3) || (c >= 25 && c <= 28);
         bit ea = (c >= 7 && c <= 16) || (c >= 32 && c <= 41);
         bit eb = (c <= 49);
         bit ed = (c == 50);
         int ei = (c < 25) ? 0 : 1;
         checks++;
         if ({QSW_EN, ACQ_WND, BUSY, DONE} !== {eq, ea, eb, ed}) begin
            errors++;
            $display("FAIL spec_example cycle %0d qsw/acq/busy/done got %b%b%b%b want %b%b%b%b",
                     c + 10, QSW_EN, ACQ_WND, BUSY, DONE, eq, ea, eb, ed);
         end
         checks++;
         if (ECHO_IDX !== ECHO_W'(ei)) begin
            errors++;
            $display("FAIL spec_example cycle %0d echo_idx got %0d want %0d", c + 10, ECHO_IDX, ei);
         end
         tick();
      end
   endtask

   task automatic test_overlap_period();
      start_seq(3, 2, 0, 6, 5);
      check_seq("overlap_p8", 3, 2, 0, 6, 5, 1'b0);
   endtask

   task automatic test_zero_cases();
      start_seq(0, 5, 5, 5, 20);
      check_seq("echo_num_zero", 0, 5, 5, 5, 20, 1'b0);
      start_seq(2, 0, 2, 3, 8);
      check_seq("qsw_zero", 2, 0, 2, 3, 8, 1'b0);
      start_seq(3, 0, 0, 0, 0);
      check_seq("all_zero", 3, 0, 0, 0, 0, 1'b0);
      start_seq(2, 4, 0, 0, 0);
      check_seq("qsw_only", 2, 4, 0, 0, 0, 1'b0);
   endtask

   task automatic test_start_while_busy();
      start_seq(2, 3, 2, 4, 12);
      check_seq("start_while_busy", 2, 3, 2, 4, 12, 1'b1);
   endtask

   task automatic test_back_to_back();
      start_seq(2, 1, 1, 2, 5);
      for (int c = 0; c < 10; c++) tick();
      checks++;
      if ({BUSY, DONE} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_done busy/done got %b%b want 01", BUSY, DONE);
      end
      start_seq(1, 2, 2, 2, 0);
      check_seq("b2b_second", 1, 2, 2, 2, 0, 1'b0);
      checks++;
      if (SEQ_STATE !== ST_IDLE) begin
         errors++;
         $display("FAIL b2b_idle state got %b want %b", SEQ_STATE, ST_IDLE);
      end
   endtask

   task automatic test_reset_mid_acq();
      start_seq(2, 4, 3, 10, 25);
      for (int c = 0; c < 8; c++) tick();
      checks++;
      if (ACQ_WND !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_acq got %b want 1", ACQ_WND);
      end
      #2 RESET = 1'b1;
      #1;
      checks++;
      if ({QSW_EN, ACQ_WND, BUSY, DONE} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset outs got %b%b%b%b want 0000", QSW_EN, ACQ_WND, BUSY, DONE);
      end
      tick();
      RESET = 1'b0;
      for (int c = 0; c < 50; c++) begin
         checks++;
         if ({ACQ_WND, BUSY, DONE} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset cycle %0d acq/busy/done got %b%b%b want 000",
                     c, ACQ_WND, BUSY, DONE);
         end
         tick();
      end
      start_seq(2, 2, 1, 3, 9);
      check_seq("after_reset", 2, 2, 1, 3, 9, 1'b0);
   endtask

`ifdef NMR_QSW_SEQ_ABORT_EN
   task automatic test_abort();
      // P=10, GAP at offsets 6..9; echo 1 GAP spans cycles 16..19.
      start_seq(4, 2, 1, 3, 10);
      for (int c = 0; c < 17; c++) tick();
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      checks++;
      if ({QSW_EN, ACQ_WND, BUSY, DONE} !== 4'b0000 || SEQ_STATE !== ST_IDLE) begin
         errors++;
         $display("FAIL abort_gap outs got %b%b%b%b state %b want 0000 state %b",
                  QSW_EN, ACQ_WND, BUSY, DONE, SEQ_STATE, ST_IDLE);
      end
      for (int c = 0; c < 30; c++) begin
         tick();
         checks++;
         if ({BUSY, DONE} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_done cycle %0d busy/done got %b%b want 00", c, BUSY, DONE);
         end
      end
      ABORT = 1'b1;
      start_seq(2, 3, 1, 2, 8);
      ABORT = 1'b0;
      for (int c = 0; c < 20; c++) begin
         checks++;
         if ({QSW_EN, BUSY, DONE} !== 3'b000 || SEQ_STATE !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_start cycle %0d qsw/busy/done got %b%b%b state %b want 000 idle",
                     c, QSW_EN, BUSY, DONE, SEQ_STATE);
         end
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_spec_example();
      test_overlap_period();
      test_zero_cases();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_acq();
`ifdef NMR_QSW_SEQ_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
